// File: rtl/rs_uart_tx.sv
// Buffered RS-232 transmitter: byte FIFO feeding an 8N1 serialiser.
// Define RS_UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module rs_uart_tx #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic [7:0] RS_DATAIN,
    input  logic       RS_TRG_WRITE,
    output logic       RS_TX,
    output logic       RS_BUSY,
    output logic       RS_FULL,
    output logic       RS_DONE,
    output logic       RS_OVF
);
    localparam int unsigned CPB = CLK_HZ / BAUD;
    localparam int unsigned CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef RS_UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic [2:0]    bidx_q, bidx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
`ifdef RS_UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif
    logic          empty, full, last, pop, push, done;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign last  = (bcnt_q == CW'(CPB - 1));
    // A full FIFO still accepts a write when the FSM pops in the same cycle.
    assign push  = RS_TRG_WRITE && (!full || pop);

    always_comb begin
        state_d = state_q;
        bcnt_d  = last ? '0 : bcnt_q + CW'(1);
        bidx_d  = bidx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
`ifdef RS_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        pop     = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                bcnt_d = '0;
                tx_d   = 1'b1;
            end
            S_START: if (last) begin
                state_d = S_DATA;
                tx_d    = shift_q[0];
            end
            S_DATA: if (last) begin
                if (bidx_q == 3'd7) begin
`ifdef RS_UART_TX_PARITY_EN
                    state_d = S_PARITY;
                    tx_d    = par_q;
`else
                    state_d = S_STOP;
                    tx_d    = 1'b1;
`endif
                end else begin
                    bidx_d  = bidx_q + 3'd1;
                    shift_d = shift_q >> 1;
                    tx_d    = shift_q[1];
                end
            end
`ifdef RS_UART_TX_PARITY_EN
            S_PARITY: if (last) begin
                state_d = S_STOP;
                tx_d    = 1'b1;
            end
`endif
            S_STOP: if (last) begin
                done    = 1'b1;
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        // Loading from IDLE and from the final STOP cycle share one path so frames chain gaplessly.
        if (!empty && (state_q == S_IDLE || (state_q == S_STOP && last))) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_q];
            bcnt_d  = '0;
            bidx_d  = '0;
            state_d = S_START;
            tx_d    = 1'b0;
`ifdef RS_UART_TX_PARITY_EN
            par_d   = ^mem_q[rd_q];
`endif
        end
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        ovf_d   = ovf_q | (RS_TRG_WRITE & ~push);
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (push) mem_q[wr_q] <= RS_DATAIN;
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            state_q <= S_IDLE;
            bcnt_q  <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef RS_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            count_q <= count_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef RS_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign RS_TX   = tx_q;
    assign RS_BUSY = (state_q != S_IDLE) || !empty;
    assign RS_FULL = full;
    assign RS_DONE = done;
    assign RS_OVF  = ovf_q;
endmodule

// File: tb/tb_rs_uart_tx.sv
// Directed bench for rs_uart_tx at default parameters (434 clocks per bit).
// Frame expectations follow RS_UART_TX_PARITY_EN when it is defined.
module tb_rs_uart_tx;
    localparam int unsigned CPB = 434;

    logic       clk = 1'b0;
    logic       RST;
    logic [7:0] RS_DATAIN;
    logic       RS_TRG_WRITE;
    logic       RS_TX, RS_BUSY, RS_FULL, RS_DONE, RS_OVF;

    int unsigned total = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;
    int unsigned done_cnt = 0;
    int unsigned d0;

    rs_uart_tx dut (
        .CLK_50MHZ   (clk),
        .RST         (RST),
        .RS_DATAIN   (RS_DATAIN),
        .RS_TRG_WRITE(RS_TRG_WRITE),
        .RS_TX       (RS_TX),
        .RS_BUSY     (RS_BUSY),
        .RS_FULL     (RS_FULL),
        .RS_DONE     (RS_DONE),
        .RS_OVF      (RS_OVF)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (RS_DONE === 1'b1) done_cnt++;

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] d);
        RS_DATAIN    = d;
        RS_TRG_WRITE = 1'b1;
        tick(1);
    endtask

    task automatic watch_high(input int unsigned n, input string tag);
        logic low_seen;
        low_seen = 1'b0;
        repeat (n) begin
            tick(1);
            if (RS_TX !== 1'b1) low_seen = 1'b1;
        end
        chk(tag, {31'b0, low_seen}, 32'd0);
    endtask

    // Entered t0 clocks after the start-bit edge; returns at the first cycle after the frame.
    task automatic check_frame(input logic [7:0] b, input int unsigned t0, input string tag);
        int unsigned dstart;
        int unsigned nbits;
        dstart = done_cnt;
        nbits  = 10;
        tick(CPB/2 - t0);
        chk($sformatf("%s.start", tag), {31'b0, RS_TX}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick(CPB);
            chk($sformatf("%s.d%0d", tag, i), {31'b0, RS_TX}, {31'b0, b[i]});
        end
`ifdef RS_UART_TX_PARITY_EN
        nbits = 11;
        tick(CPB);
        chk($sformatf("%s.par", tag), {31'b0, RS_TX}, {31'b0, ^b});
`endif
        tick(CPB);
        chk($sformatf("%s.stop", tag), {31'b0, RS_TX}, 32'd1);
        tick(CPB - CPB/2 - 1);
        chk($sformatf("%s.done_last", tag), {31'b0, RS_DONE}, 32'd1);
        chk($sformatf("%s.busy_last", tag), {31'b0, RS_BUSY}, 32'd1);
        chk($sformatf("%s.done_early", tag), done_cnt, dstart);
        tick(1);
        chk($sformatf("%s.done_after", tag), {31'b0, RS_DONE}, 32'd0);
        chk($sformatf("%s.done_once", tag), done_cnt, dstart + 1);
        chk($sformatf("%s.nbits", tag), nbits, (CPB/2 + (nbits-1)*CPB + CPB - CPB/2) / CPB);
    endtask

    initial begin
        RST          = 1'b1;
        RS_DATAIN    = 8'h00;
        RS_TRG_WRITE = 1'b0;
        tick(3);
        RST = 1'b0;
        chk("rst.tx",   {31'b0, RS_TX},   32'd1);
        chk("rst.busy", {31'b0, RS_BUSY}, 32'd0);
        chk("rst.full", {31'b0, RS_FULL}, 32'd0);
        chk("rst.ovf",  {31'b0, RS_OVF},  32'd0);
        chk("rst.done", {31'b0, RS_DONE}, 32'd0);
        watch_high(1000, "idle.line_high");

        // Single byte: write edge N, start bit from edge N+1
        put(8'hA5);
        RS_TRG_WRITE = 1'b0;
        chk("a5.busy_queued", {31'b0, RS_BUSY}, 32'd1);
        chk("a5.tx_before",   {31'b0, RS_TX},   32'd1);
        tick(1);
        check_frame(8'hA5, 0, "a5");
        chk("a5.busy_end", {31'b0, RS_BUSY}, 32'd0);
        chk("a5.tx_end",   {31'b0, RS_TX},   32'd1);

`ifdef RS_UART_TX_PARITY_EN
        put(8'h03);
        RS_TRG_WRITE = 1'b0;
        tick(1);
        check_frame(8'h03, 0, "p03");
        put(8'h07);
        RS_TRG_WRITE = 1'b0;
        tick(1);
        check_frame(8'h07, 0, "p07");
`endif

        // Back-to-back: first byte popped one edge after its write
        d0 = done_cnt;
        put(8'h11);
        put(8'h22);
        put(8'h33);
        put(8'h44);
        RS_TRG_WRITE = 1'b0;
        chk("b2b.full", {31'b0, RS_FULL}, 32'd0);
        chk("b2b.busy", {31'b0, RS_BUSY}, 32'd1);
        check_frame(8'h11, 2, "b2b0");
        check_frame(8'h22, 0, "b2b1");
        check_frame(8'h33, 0, "b2b2");
        check_frame(8'h44, 0, "b2b3");
        chk("b2b.busy_end", {31'b0, RS_BUSY}, 32'd0);
        chk("b2b.dones", done_cnt, d0 + 4);

        // Overflow: one popped, four buffered, sixth dropped
        chk("ovf.pre", {31'b0, RS_OVF}, 32'd0);
        d0 = done_cnt;
        put(8'h61);
        put(8'h62);
        put(8'h63);
        put(8'h64);
        put(8'h65);
        put(8'h66);
        RS_TRG_WRITE = 1'b0;
        chk("ovf.full", {31'b0, RS_FULL}, 32'd1);
        chk("ovf.set",  {31'b0, RS_OVF},  32'd1);
        check_frame(8'h61, 4, "ovf0");
        check_frame(8'h62, 0, "ovf1");
        check_frame(8'h63, 0, "ovf2");
        check_frame(8'h64, 0, "ovf3");
        check_frame(8'h65, 0, "ovf4");
        chk("ovf.busy_end", {31'b0, RS_BUSY}, 32'd0);
        chk("ovf.sticky",   {31'b0, RS_OVF},  32'd1);
        chk("ovf.dones",    done_cnt, d0 + 5);
        watch_high(2*CPB, "ovf.no_sixth");

        // Reset during data bit 3 of 0xFF with two bytes queued
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        chk("mid.ovf_cleared", {31'b0, RS_OVF}, 32'd0);
        put(8'hFF);
        put(8'hAA);
        put(8'hBB);
        RS_TRG_WRITE = 1'b0;
        tick(4*CPB + CPB/2 - 1);
        chk("mid.bit3", {31'b0, RS_TX}, 32'd1);
        chk("mid.busy_before", {31'b0, RS_BUSY}, 32'd1);
        d0 = done_cnt;
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        chk("mid.tx",   {31'b0, RS_TX},   32'd1);
        chk("mid.busy", {31'b0, RS_BUSY}, 32'd0);
        chk("mid.full", {31'b0, RS_FULL}, 32'd0);
        chk("mid.done", {31'b0, RS_DONE}, 32'd0);
        watch_high(12*CPB, "mid.no_frames");
        chk("mid.no_done", done_cnt, d0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
